cbus_arbiter: RTL and testbench
===============================

CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 2, number of requester ports (2..8).
REQ-002 SHALL have port aclk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ireqs  input  NUM_INPUTS x cbus_req_t  requester requests: valid, is_write, size, addr, strobe, data, len.
REQ-005 SHALL have port iresps  output  NUM_INPUTS x cbus_resp_t  per-requester responses: ready, last, data.
REQ-006 SHALL have port oreq  output  cbus_req_t  request to the shared bus, consumed by the AXI bridge driving the AXI3 master port.
REQ-007 SHALL have port oresp  input  cbus_resp_t  response from the shared bus.

Function
REQ-008 SHALL implement a two-state FSM: IDLE (no grant) and BUSY (grant held by index register sel, width clog2(NUM_INPUTS)).
REQ-009 SHALL, in IDLE with one or more ireqs[i].valid, pick the first valid index searching round-robin from (last+1) mod NUM_INPUTS, load sel, and enter BUSY next cycle.
REQ-010 SHALL update last to sel on each grant; last resets to NUM_INPUTS-1, so index 0 wins the first contention.
REQ-011 SHALL stay in IDLE when no ireqs[i].valid is asserted.
REQ-012 SHALL drive oreq from registered state only: in IDLE oreq = all-zero (valid=0); in BUSY oreq = ireqs[sel], passed combinationally.
REQ-013 SHALL route oresp to iresps[sel] only while BUSY; all other iresps, and all iresps in IDLE, SHALL be all-zero (ready=0, last=0, data=0).
REQ-014 SHALL leave BUSY for IDLE on the cycle after oresp.ready && oresp.last while BUSY (transaction complete, single or burst).
REQ-015 SHALL NOT grant on the cycle the FSM returns to IDLE; first re-grant is visible on oreq two cycles after the completing beat (one idle bubble).
REQ-016 SHALL hold sel constant for the whole of BUSY regardless of other requesters' valid changes.
REQ-017 SHALL, if ireqs[sel].valid deasserts in BUSY without a completing beat, return to IDLE next cycle (abort); oreq.valid then follows the requester (0) that cycle.
REQ-018 SHALL treat a completing beat coinciding with a new request from the same or another requester per REQ-014/015; priority then uses the updated last.
REQ-019 SHALL handle any beat count (len) and both directions identically; burst beats are counted by oresp.last only, never internally.
REQ-020 SHALL ignore oresp entirely in IDLE.
REQ-021 SHALL have request-to-oreq latency of 1 cycle from the cycle ireqs[i].valid is first sampled in IDLE.

Reset
REQ-022 SHALL, when reset is high at a rising edge, enter IDLE, set sel=0, last=NUM_INPUTS-1, regardless of state.
REQ-023 SHALL drive oreq.valid=0 and all iresps zero in the cycle after reset, including reset asserted mid-burst; no partial response is forwarded afterwards.
REQ-024 SHALL not grant while reset is high.

Verification
REQ-025 SHALL pass: only ireqs[1] valid, single read, oresp ready+last with data 0x1234_5678 one cycle after grant -> oreq==ireqs[1] from cycle 1, iresps[1].data=0x1234_5678, iresps[0] all zero, IDLE after.
REQ-026 SHALL pass: ireqs[0] and ireqs[1] both valid continuously, four single-beat transactions -> grants in order 0,1,0,1, one idle bubble between each.
REQ-027 SHALL pass: ireqs[0] 4-beat read (len=3), ireqs[1] valid during burst -> sel stays 0 through beats 1-4, last=1 only on beat 4, ireqs[1] granted 2 cycles after beat 4.
REQ-028 SHALL pass: reset asserted on beat 2 of a 4-beat write from ireqs[1] -> next cycle oreq.valid=0, iresps zero, then ireqs[0] and ireqs[1] both valid -> index 0 granted first.
REQ-029 SHALL pass: granted requester drops valid in BUSY with oresp.ready=0 -> IDLE next cycle, pending other requester granted on the following cycle.

Source files
------------

// File: rtl/cbus_arbiter_if.sv
// Shared-bus request/response types and the arbiter's bus-side interface.
`default_nettype none

package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

interface cbus_arbiter_if #(parameter int NUM_INPUTS = 2);
  import cbus_pkg::*;

  cbus_req_t  ireqs  [NUM_INPUTS];
  cbus_resp_t iresps [NUM_INPUTS];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  // slave is the arbiter side; master is the requesters plus bridge side
  modport slave  (input ireqs, output iresps, output oreq, input oresp);
  modport master (output ireqs, input iresps, input oreq, output oresp);
endinterface

`default_nettype wire

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter granting one of NUM_INPUTS requesters the shared bus
// for a whole transaction, released on the final response beat or on abort.
`default_nettype none

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS = 2
) (
  input  logic           aclk,
  input  logic           reset,
  cbus_arbiter_if.slave  bus
);

  localparam int              SEL_W    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_INPUTS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] pick;
  logic             any_valid;
  logic             grant;

  // Scan from the farthest offset down so the nearest valid index after last wins.
  always_comb begin
    pick      = '0;
    any_valid = 1'b0;
    for (int k = NUM_INPUTS; k >= 1; k--) begin
      if (bus.ireqs[(int'(last) + k) % NUM_INPUTS].valid) begin
        pick      = SEL_W'((int'(last) + k) % NUM_INPUTS);
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          grant    = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (bus.oresp.ready && bus.oresp.last) begin
          state_nx = IDLE;
        end else if (!bus.ireqs[sel].valid) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state <= IDLE;
      sel   <= '0;
      last  <= LAST_RST;
    end else begin
      state <= state_nx;
      if (grant) begin
        sel  <= pick;
        last <= pick;
      end
    end
  end

  // Bus-facing outputs depend only on registered state plus the selected pass-through.
  always_comb begin
    bus.oreq = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      bus.iresps[i] = '0;
    end
    if (state == BUSY) begin
      bus.oreq        = bus.ireqs[sel];
      bus.iresps[sel] = bus.oresp;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cbus_arbiter.sv
// Directed-vector bench for cbus_arbiter with a queue-based scoreboard and monitor.
`default_nettype none

module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int N = 2;

  typedef struct {
    int         cyc;
    cbus_req_t  oreq;
    int         idx;
    cbus_resp_t resp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sbq [$];

  cbus_arbiter_if #(.NUM_INPUTS(N)) bus ();

  cbus_arbiter #(.NUM_INPUTS(N)) dut (
    .aclk  (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic cbus_req_t mk_req(int i, logic v);
    cbus_req_t r;
    r.valid    = v;
    r.is_write = (i == 1);
    r.size     = 3'd2;
    r.addr     = 32'h1000 * (i + 1) + 32'h40;
    r.strobe   = 4'hf;
    r.data     = 32'hC0DE_0000 + i;
    r.len      = 8'd3;
    return r;
  endfunction

  // One vector per cycle: inputs for this cycle and the index expected to own the bus.
  task automatic row(input logic r, input logic [N-1:0] v, input logic rdy,
                     input logic lst, input logic [31:0] d, input int exp_idx);
    exp_t e;
    rst = r;
    for (int i = 0; i < N; i++) bus.ireqs[i] = mk_req(i, v[i]);
    bus.oresp.ready = rdy;
    bus.oresp.last  = lst;
    bus.oresp.data  = d;
    e.cyc  = cyc;
    e.idx  = exp_idx;
    e.oreq = (exp_idx >= 0) ? mk_req(exp_idx, v[exp_idx]) : '0;
    e.resp = bus.oresp;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t       e;
    cbus_resp_t want;
    bit         active;
    active = (bus.oreq != '0);
    for (int i = 0; i < N; i++) if (bus.iresps[i] != '0) active = 1'b1;
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      e = sbq.pop_front();
      tests++;
      if (bus.oreq !== e.oreq) begin
        fails++;
        $display("FAIL oreq cyc=%0d got=%h want=%h", cyc, bus.oreq, e.oreq);
      end
      for (int i = 0; i < N; i++) begin
        want = (i == e.idx) ? e.resp : '0;
        tests++;
        if (bus.iresps[i] !== want) begin
          fails++;
          $display("FAIL iresps[%0d] cyc=%0d got=%h want=%h", i, cyc, bus.iresps[i], want);
        end
      end
    end else if (active) begin
      tests++;
      fails++;
      $display("FAIL unexpected_output cyc=%0d oreq=%h", cyc, bus.oreq);
    end
  end

  initial begin
    for (int i = 0; i < N; i++) bus.ireqs[i] = '0;
    bus.oresp = '0;
    @(posedge clk);
    #1;
    // reset state, no grant while reset is held
    row(1, 2'b11, 0, 0, 32'h0, -1);
    row(1, 2'b11, 0, 0, 32'h0, -1);
    // both requesters continuously valid: grants 0,1,0,1 with a bubble between
    row(0, 2'b11, 0, 0, 32'h0, -1);
    row(0, 2'b11, 1, 1, 32'hA000_0000, 0);
    row(0, 2'b11, 0, 0, 32'h0, -1);
    row(0, 2'b11, 1, 1, 32'hA000_0001, 1);
    row(0, 2'b11, 0, 0, 32'h0, -1);
    row(0, 2'b11, 1, 1, 32'hA000_0002, 0);
    row(0, 2'b11, 0, 0, 32'h0, -1);
    row(0, 2'b11, 1, 1, 32'hA000_0003, 1);
    row(0, 2'b00, 0, 0, 32'h0, -1);
    // single read from requester 1; response in IDLE must be ignored
    row(0, 2'b10, 0, 0, 32'h0, -1);
    row(0, 2'b10, 1, 1, 32'h1234_5678, 1);
    row(0, 2'b00, 1, 1, 32'hDEAD_BEEF, -1);
    row(0, 2'b00, 0, 0, 32'h0, -1);
    // 4-beat burst from 0 with a wait state; 1 waits and wins two cycles after beat 4
    row(0, 2'b01, 0, 0, 32'h0, -1);
    row(0, 2'b11, 1, 0, 32'hB000_0000, 0);
    row(0, 2'b11, 1, 0, 32'hB000_0001, 0);
    row(0, 2'b11, 0, 0, 32'h0, 0);
    row(0, 2'b11, 1, 0, 32'hB000_0002, 0);
    row(0, 2'b11, 1, 1, 32'hB000_0003, 0);
    row(0, 2'b10, 0, 0, 32'h0, -1);
    row(0, 2'b10, 0, 0, 32'h0, 1);
    row(0, 2'b10, 1, 1, 32'hC000_0000, 1);
    row(0, 2'b00, 0, 0, 32'h0, -1);
    // reset on beat 2 of a write burst from 1, then contention goes to 0
    row(0, 2'b10, 0, 0, 32'h0, -1);
    row(0, 2'b10, 1, 0, 32'hD000_0000, 1);
    row(1, 2'b10, 1, 0, 32'hD000_0001, 1);
    row(1, 2'b11, 1, 0, 32'hD000_0002, -1);
    row(0, 2'b11, 0, 0, 32'h0, -1);
    row(0, 2'b11, 1, 1, 32'hE000_0000, 0);
    // granted requester 1 drops valid without a beat: abort, then 0 is granted
    row(0, 2'b11, 0, 0, 32'h0, -1);
    row(0, 2'b01, 0, 0, 32'h0, 1);
    row(0, 2'b01, 0, 0, 32'h0, -1);
    row(0, 2'b01, 1, 1, 32'hE000_0001, 0);
    row(0, 2'b00, 0, 0, 32'h0, -1);
    row(0, 2'b00, 0, 0, 32'h0, -1);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d want=0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
